seg7_edit_ctrl: RTL and testbench

Cursor-based edit controller for the 8-digit, 6-bit-per-character seven-segment display path. It debounces the five push-buttons and turns presses into cursor moves and character increments/decrements, with auto-repeat on up/down. It owns the 48-bit frame buffer, the cursor one-hot `dp`, and the blink mask `star`. These outputs feed the star-control display driver directly and replace the ad-hoc divided-clock logic in the top level.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 82 ++++++++
 rtl/seg7_edit_ctrl.sv | 88 ++++++++
 tb/tb_seg7_edit_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment edit path.
package seg7_pkg;

  localparam int unsigned CHAR_W = 6;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned BTN_N  = 5;

  // "SUCCESS!" code string, digit 0 in the low six bits
  localparam logic [CHAR_W*DIGITS-1:0] INIT_FRAME = 48'h71E3_0C39_C726;

  localparam int unsigned BTN_LEFT   = 0;
  localparam int unsigned BTN_UP     = 1;
  localparam int unsigned BTN_RIGHT  = 2;
  localparam int unsigned BTN_DOWN   = 3;
  localparam int unsigned BTN_CENTER = 4;

  localparam logic [CHAR_W-1:0] CHAR_MAX = '1;
  localparam logic [2:0]        CUR_MAX  = 3'(DIGITS - 1);

  typedef enum logic {
    ST_EDIT   = 1'b0,
    ST_LOCKED = 1'b1
  } edit_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF synchroniser, stable-count debouncer, press pulse
// and optional hold-to-repeat pulses.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic event_o
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic            sync1_q, sync2_q;
  logic            level_q;
  logic            press_q;
  logic [DB_W-1:0] db_cnt_q;

  logic [RPT_W-1:0] rpt_cnt_q;
  logic             rpt_active_q;
  logic             rpt_period_q;
  logic             rpt_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // Counts consecutive samples disagreeing with the accepted level
      if (sync2_q == level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt_q <= '0;
        level_q  <= sync2_q;
        press_q  <= sync2_q;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  // rpt_cnt_q equals cycles elapsed since the last press/repeat pulse
  assign rpt_fire = rpt_active_q & level_q &
                    (rpt_cnt_q == (rpt_period_q ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rpt_cnt_q    <= '0;
      rpt_active_q <= 1'b0;
      rpt_period_q <= 1'b0;
    end else if (press_q) begin
      rpt_cnt_q    <= RPT_W'(1);
      rpt_active_q <= 1'b1;
      rpt_period_q <= 1'b0;
    end else if (!level_q) begin
      rpt_cnt_q    <= '0;
      rpt_active_q <= 1'b0;
      rpt_period_q <= 1'b0;
    end else if (rpt_active_q) begin
      if (rpt_fire) begin
        rpt_cnt_q    <= RPT_W'(1);
        rpt_period_q <= 1'b1;
      end else begin
        rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  assign event_o = press_q | (REPEAT_EN & rpt_fire);

endmodule

// File: rtl/seg7_edit_ctrl.sv
// Cursor-based edit controller: owns the frame buffer, cursor and blink mask
// for the 8-digit seven-segment display.
module seg7_edit_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic                     clk_pin,
  input  logic                     rst_n,
  input  logic [BTN_N-1:0]         btn,
  output logic [CHAR_W*DIGITS-1:0] num,
  output logic [DIGITS-1:0]        dp,
  output logic [DIGITS-1:0]        star,
  output logic                     editing,
  output logic [CHAR_W-1:0]        char_cur
);

  logic [BTN_N-1:0] ev;

  for (genvar i = 0; i < BTN_N; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (i == BTN_UP || i == BTN_DOWN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_db (
      .clk_i  (clk_pin),
      .rst_ni (rst_n),
      .btn_i  (btn[i]),
      .event_o(ev[i])
    );
  end

  edit_state_e              state_q;
  logic [CHAR_W*DIGITS-1:0] num_q;
  logic [2:0]               cur_q;
  logic [DIGITS-1:0]        dp_q;
  logic [DIGITS-1:0]        star_q;
  logic [CHAR_W-1:0]        char_w;

  assign char_w = num_q[cur_q*CHAR_W +: CHAR_W];

  // Priority chain drops every lower-priority event arriving the same cycle
  always_ff @(posedge clk_pin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EDIT;
      num_q   <= INIT_FRAME;
      cur_q   <= '0;
      dp_q    <= 8'h01;
      star_q  <= 8'h01;
    end else if (ev[BTN_CENTER]) begin
      if (state_q == ST_EDIT) begin
        state_q <= ST_LOCKED;
        star_q  <= '0;
      end else begin
        state_q <= ST_EDIT;
        star_q  <= dp_q;
      end
    end else if (state_q == ST_EDIT) begin
      if (ev[BTN_LEFT]) begin
        if (cur_q != CUR_MAX) begin
          cur_q  <= cur_q + 3'd1;
          dp_q   <= dp_q << 1;
          star_q <= dp_q << 1;
        end
      end else if (ev[BTN_RIGHT]) begin
        if (cur_q != '0) begin
          cur_q  <= cur_q - 3'd1;
          dp_q   <= dp_q >> 1;
          star_q <= dp_q >> 1;
        end
      end else if (ev[BTN_UP]) begin
        if (char_w != CHAR_MAX) num_q[cur_q*CHAR_W +: CHAR_W] <= char_w + 6'd1;
      end else if (ev[BTN_DOWN]) begin
        if (char_w != '0) num_q[cur_q*CHAR_W +: CHAR_W] <= char_w - 6'd1;
      end
    end
  end

  assign num      = num_q;
  assign dp       = dp_q;
  assign star     = star_q;
  assign editing  = (state_q == ST_EDIT);
  assign char_cur = char_w;

endmodule

// File: tb/tb_seg7_edit_ctrl.sv
// Randomised self-checking bench for seg7_edit_ctrl against a digit-array model.
module tb_seg7_edit_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 5;
  localparam logic [47:0] INIT = 48'h71E30C39C726;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  btn = '0;
  logic [47:0] num;
  logic [7:0]  dp, star;
  logic        editing;
  logic [5:0]  char_cur;

  seg7_edit_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_pin (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .num     (num),
    .dp      (dp),
    .star    (star),
    .editing (editing),
    .char_cur(char_cur)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_ch[8];
  int exp_cur;
  bit exp_edit;
  int chg_q[$];

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) exp_ch[k] = int'((INIT >> (6 * k)) & 48'h3F);
    exp_cur  = 0;
    exp_edit = 1'b1;
  endfunction

  // b: 0 left, 1 up, 2 right, 3 down, 4 centre
  function automatic void model_event(input int b);
    if (b == 4) exp_edit = !exp_edit;
    else if (exp_edit) begin
      case (b)
        0: if (exp_cur < 7) exp_cur++;
        2: if (exp_cur > 0) exp_cur--;
        1: if (exp_ch[exp_cur] < 63) exp_ch[exp_cur]++;
        3: if (exp_ch[exp_cur] > 0) exp_ch[exp_cur]--;
        default: ;
      endcase
    end
  endfunction

  function automatic void model_mask(input logic [4:0] m);
    int prio[5] = '{4, 0, 2, 1, 3};
    for (int i = 0; i < 5; i++)
      if (m[prio[i]]) begin
        model_event(prio[i]);
        return;
      end
  endfunction

  function automatic int repeats(input int h);
    return (h - 1 >= int'(RD)) ? (h - 1 - int'(RD)) / int'(RP) + 1 : 0;
  endfunction

  function automatic logic [47:0] model_num();
    logic [47:0] r = '0;
    for (int k = 0; k < 8; k++) r |= 48'(exp_ch[k]) << (6 * k);
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] edp = 8'(1 << exp_cur);
    check_eq({tag, ".num"},      num,      model_num());
    check_eq({tag, ".dp"},       dp,       edp);
    check_eq({tag, ".star"},     star,     exp_edit ? edp : 8'h00);
    check_eq({tag, ".editing"},  editing,  exp_edit);
    check_eq({tag, ".char_cur"}, char_cur, 48'(exp_ch[exp_cur]));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive mask for h cycles (optionally bouncing first), release, let it settle.
  // Records the cycle index of every num change into chg_q.
  task automatic press(input logic [4:0] m, input int h, input bit bounce);
    logic [47:0] prev;
    chg_q.delete();
    if (bounce) begin
      repeat (2) begin
        btn = m;
        tick($urandom_range(1, DB - 1));
        btn = '0;
        tick($urandom_range(1, 2));
      end
    end
    btn = m;
    for (int i = 0; i < h + int'(DB) + 10; i++) begin
      if (i == h) btn = '0;
      prev = num;
      tick(1);
      if (num !== prev) chg_q.push_back(i);
    end
    model_mask(m);
    if (m == 5'b00010 || m == 5'b01000)
      for (int r = 0; r < repeats(h); r++) model_mask(m);
  endtask

  initial begin
    int kind, b, h;
    model_reset();

    // Reset state
    tick(2);
    check_all("rst_held");
    rst_n = 1'b1;
    tick(2);
    check_all("rst");

    // Bounce of 3 cycles then a 10 cycle hold: one event only
    btn = 5'b00010;
    tick(3);
    btn = '0;
    tick(2);
    press(5'b00010, 10, 1'b0);
    check_eq("bounce.digit0", num[5:0], 48'd39);
    check_eq("bounce.others", num[47:6], INIT[47:6]);
    check_eq("bounce.nchg", chg_q.size(), 48'd1);
    check_all("bounce");

    // Cursor saturation both ways
    for (int i = 1; i <= 9; i++) begin
      press(5'b00001, 8, 1'b0);
      if (i == 7 || i == 9) check_eq($sformatf("left%0d.dp", i), dp, 48'h80);
    end
    for (int i = 1; i <= 9; i++) press(5'b00100, 8, 1'b0);
    check_eq("right9.dp", dp, 48'h01);
    check_all("cursor_sat");

    // Climb digit 2 from 28 to 62 with auto-repeat and check repeat spacing
    press(5'b00001, 8, 1'b0);
    press(5'b00001, 8, 1'b0);
    press(5'b00010, 183, 1'b0);
    check_eq("climb.digit2", num[17:12], 48'd62);
    check_eq("climb.digit1", num[11:6], INIT[11:6]);
    check_eq("climb.nchg", chg_q.size(), 48'd34);
    if (chg_q.size() >= 3) begin
      check_eq("rpt.first",  chg_q[1] - chg_q[0], 48'(RD));
      check_eq("rpt.second", chg_q[2] - chg_q[1], 48'(RP));
    end
    press(5'b00010, int'(DB) + 2 + 40, 1'b0);
    check_eq("sat63.digit2", num[17:12], 48'd63);
    check_eq("sat63.nchg", chg_q.size(), 48'd1);
    check_all("sat63");

    // Locked mode freezes edits
    press(5'b10000, 8, 1'b0);
    press(5'b00001, 8, 1'b0);
    press(5'b00010, 8, 1'b0);
    check_eq("locked.editing", editing, 48'd0);
    check_eq("locked.star", star, 48'd0);
    check_all("locked");
    press(5'b10000, 8, 1'b0);
    check_eq("unlock.star", star, 48'(dp));
    check_all("unlock");

    // Left and up together: cursor moves, character untouched
    press(5'b00011, 10, 1'b0);
    check_all("left_up");

    // Randomised operations
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        b = $urandom_range(0, 4);
        press(5'(1 << b), $urandom_range(6, 17), 1'($urandom_range(0, 1)));
      end else if (kind <= 7) begin
        press(5'($urandom_range(1, 31)), $urandom_range(6, 17), 1'b0);
      end else begin
        h = 23 + 5 * $urandom_range(0, 4);
        press((kind == 8) ? 5'b00010 : 5'b01000, h, 1'b0);
      end
      check_all($sformatf("rnd%0d", r));
    end

    // Reset while down is held: press discarded, re-detected after a full window
    btn = 5'b01000;
    tick(int'(DB) + 7);
    rst_n = 1'b0;
    tick(1);
    model_reset();
    check_all("midrst_held");
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check_eq("midrst.nowin", num, INIT);
    tick(10);
    btn = '0;
    tick(int'(DB) + 10);
    model_event(3);
    check_all("midrst_after");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
